// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: NCH valid/ready input channels, one registered output.
// master = sources plus consumer (drives offers and out_ready); slave = the mux.
interface mux_arb_reg_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [SELW-1:0]        out_ch;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/mux_arb_reg.sv
// N-channel registered mux with directed or round-robin selection into a
// one-entry output register that may drain and refill in the same cycle.
module mux_arb_reg #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    mux_arb_reg_if.slave  bus
);
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_can_accept;
    logic             w_grant_vld;
    logic [SELW-1:0]  w_grant;
    logic             w_cand_vld;
    logic [SELW-1:0]  w_cand;
    logic [NCH-1:0]   w_in_ready;
    logic             w_xfer;

    function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCH) s -= NCH;
        return SELW'(s);
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_can_accept = !r_out_valid || bus.out_ready;
        w_grant_vld  = 1'b0;
        w_grant      = '0;
        w_cand_vld   = 1'b0;
        w_cand       = '0;
        if (!bus.mode) begin
            // The directed candidate is offered ready whether or not it is valid.
            if (int'(bus.sel) < NCH) begin
                w_cand_vld  = 1'b1;
                w_cand      = bus.sel;
                w_grant     = bus.sel;
                w_grant_vld = bus.in_valid[bus.sel];
            end
        end else begin
            // Walk offsets downward so the channel nearest ptr wins.
            for (int i = NCH - 1; i >= 0; i--) begin
                if (bus.in_valid[rr_idx(r_ptr, i)]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = rr_idx(r_ptr, i);
                end
            end
            w_cand_vld = w_grant_vld;
            w_cand     = w_grant;
        end
    end

    always_comb begin
        w_in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            w_in_ready[k] = w_can_accept && w_cand_vld && (w_cand == SELW'(k)) && !rst;
        end
    end

    assign w_xfer = w_can_accept && w_grant_vld;

    // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= bus.in_data[int'(w_grant)*WIDTH +: WIDTH];
            r_out_ch    <= w_grant;
            r_out_valid <= 1'b1;
            if (bus.mode) begin
                r_ptr <= (w_grant == SELW'(NCH - 1)) ? '0 : w_grant + 1'b1;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg: directed scenarios plus a randomized run
// compared each cycle against a transaction-level reference model.
module tb_mux_arb_reg;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int W3 = 8;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_arb_reg_if #(.WIDTH(W),  .NCH(N),  .SELW(S)) bus ();
    mux_arb_reg_if #(.WIDTH(W3), .NCH(N3), .SELW(S)) bus3 ();

    mux_arb_reg #(.WIDTH(W),  .NCH(N),  .SELW(S)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    mux_arb_reg #(.WIDTH(W3), .NCH(N3), .SELW(S)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the held word and the next channel round-robin looks at first.
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_ch;
    int          m_ptr;

    function automatic int rr_pick(input logic [N-1:0] v, input int start);
        for (int off = 0; off < N; off++) begin
            if (v[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (rst || (m_valid && !bus.out_ready)) return r;
        if (!bus.mode) begin
            if (int'(bus.sel) < N) r[bus.sel] = 1'b1;
        end else begin
            g = rr_pick(bus.in_valid, m_ptr);
            if (g >= 0) r[g] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_update();
        int g;
        if (rst) begin
            m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
        end else begin
            if (bus.mode) g = rr_pick(bus.in_valid, m_ptr);
            else g = (int'(bus.sel) < N && bus.in_valid[bus.sel]) ? int'(bus.sel) : -1;
            if ((!m_valid || bus.out_ready) && g >= 0) begin
                m_data  = bus.in_data[g*W +: W];
                m_ch    = g;
                m_valid = 1;
                if (bus.mode) m_ptr = (g + 1) % N;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = '1; bus.out_ready = 1'b1;
        set_data(32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b0 ||
                bus.out_data !== 32'h0 || bus.out_ch !== 2'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: rdy=%b vld=%b data=%h ch=%0d, want 0000/0/0/0",
                         i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_ch);
            end
            tick();
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.in_ready !== 4'b0001) begin
            n_err++; $display("FAIL reset_release_ready: got %b want 0001", bus.in_ready);
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 32'hC0DE_0000) begin
            n_err++;
            $display("FAIL first_capture: vld=%b ch=%0d data=%h, want 1/0/c0de0000",
                     bus.out_valid, bus.out_ch, bus.out_data);
        end
    endtask

    task automatic test_directed();
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = '1; bus.out_ready = 1'b1;
        set_data(32'h1111_0000, 32'h2222_0001, 32'hA5A5_0002, 32'h4444_0003);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (bus.in_ready !== 4'b0100) begin
                n_err++; $display("FAIL directed_ready cyc%0d: got %b want 0100", i, bus.in_ready);
            end
            tick();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd2 || bus.out_data !== 32'hA5A5_0002) begin
                n_err++;
                $display("FAIL directed_out cyc%0d: vld=%b ch=%0d data=%h, want 1/2/a5a50002",
                         i, bus.out_valid, bus.out_ch, bus.out_data);
            end
        end
    endtask

    task automatic test_rr_fairness();
        int exp_all [6] = '{0, 1, 2, 3, 0, 1};
        int exp_odd [4] = '{1, 3, 1, 3};
        pulse_reset();
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_ch) != exp_all[i]) begin
                n_err++;
                $display("FAIL rr_all step%0d: vld=%b ch=%0d want ch %0d", i, bus.out_valid, bus.out_ch, exp_all[i]);
            end
        end
        pulse_reset();
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_ch) != exp_odd[i]) begin
                n_err++;
                $display("FAIL rr_odd step%0d: vld=%b ch=%0d want ch %0d", i, bus.out_valid, bus.out_ch, exp_odd[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        bus.mode = 1'b0; bus.sel = 2'd0; bus.in_valid = 4'b0001; bus.out_ready = 1'b0;
        set_data(32'h11, 32'h22, 32'h33, 32'h44);
        tick();
        bus.sel = 2'd1; bus.in_valid = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11 || bus.out_ch !== 2'd0 ||
                bus.in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL stall cyc%0d: vld=%b data=%h ch=%0d rdy=%b, want 1/11/0/0000",
                         i, bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 4'b0010) begin
            n_err++; $display("FAIL drain_ready: got %b want 0010", bus.in_ready);
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h22 || bus.out_ch !== 2'd1) begin
            n_err++;
            $display("FAIL refill_no_bubble: vld=%b data=%h ch=%0d, want 1/22/1",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        set_data(32'h5000, 32'h5001, 32'h5002, 32'h5003);
        tick();
        rst = 1'b1;
        tick();
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid: vld=%b data=%h rdy=%b, want 0/0/0000",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        rst = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_ch) != i || bus.out_data !== 32'h5000 + W'(i)) begin
                n_err++;
                $display("FAIL rr_restart step%0d: vld=%b ch=%0d data=%h, want ch %0d",
                         i, bus.out_valid, bus.out_ch, bus.out_data, i);
            end
        end
    endtask

    task automatic test_boundary_nch3();
        int exp_seq [4] = '{0, 1, 2, 0};
        bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
        bus3.in_data = {8'hC2, 8'hC1, 8'hC0};
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (bus3.in_ready !== 3'b000 || bus3.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL nch3_sel_oob cyc%0d: rdy=%b vld=%b, want 000/0", i, bus3.in_ready, bus3.out_valid);
            end
            tick();
        end
        bus3.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (bus3.out_valid !== 1'b1 || int'(bus3.out_ch) != exp_seq[i] ||
                bus3.out_data !== 8'hC0 + 8'(exp_seq[i])) begin
                n_err++;
                $display("FAIL nch3_wrap step%0d: vld=%b ch=%0d data=%h, want ch %0d",
                         i, bus3.out_valid, bus3.out_ch, bus3.out_data, exp_seq[i]);
            end
        end
        // After grant 0 ptr is 1; only ch2 valid forces grant 2, then ptr must wrap to 0.
        bus3.in_valid = 3'b100;
        tick();
        bus3.in_valid = 3'b011;
        tick();
        n_vec++;
        if (bus3.out_ch !== 2'd0) begin
            n_err++; $display("FAIL nch3_ptr_wrap: ch=%0d want 0", bus3.out_ch);
        end
        bus3.in_valid = 3'b000;
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 99) < 2);
            bus.mode      = $urandom_range(0, 1) == 1;
            bus.sel       = S'($urandom_range(0, N - 1));
            bus.in_valid  = N'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = $urandom;
            #1;
            n_vec++;
            if (bus.in_ready !== exp_ready() || bus.out_valid !== m_valid ||
                bus.out_data !== m_data || int'(bus.out_ch) != m_ch) begin
                n_err++;
                $display("FAIL random cyc%0d: rdy=%b vld=%b data=%h ch=%0d, want %b/%b/%h/%0d",
                         c, bus.in_ready, bus.out_valid, bus.out_data, bus.out_ch,
                         exp_ready(), m_valid, m_data, m_ch);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
        bus.mode = 1'b0; bus.sel = '0; bus.in_data = '0; bus.in_valid = '0; bus.out_ready = 1'b0;
        bus3.mode = 1'b0; bus3.sel = '0; bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_rr_fairness();
        test_backpressure();
        test_reset_mid();
        test_boundary_nch3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
